md_iter_unit: RTL and testbench
===============================

Name: md_iter_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO.
- Divide is a true iterative restoring divider; multiply is a single product held for a programmable latency.
- New versus the previous unit: width parameter, accumulate modes, exception cancel/abort, divide-by-zero flag, and a completion pulse. HI/LO commit at completion, not at issue.

Parameters:
- WIDTH, 32, operand/HI/LO width (>=8).
- MUL_LAT, 5, busy cycles for multiply-class ops (>=1).
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_LAT, WIDTH+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  issue strobe, sampled at clk edge.
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, 10-15 no-op.
- cancel  in  1  exception flush: qualifies start; aborts an in-flight op.
- a  in  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO data).
- b  in  WIDTH  rt operand (divisor, multiplier).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  op in flight.
- done  out  1  one-cycle pulse; HI/LO just committed.
- dz  out  1  with done: completed op was a divide by zero.

Behaviour:
- Reset (async, any time including mid-op):
  - hi=lo=0, busy=0, done=0, dz=0, state IDLE, counter 0.
  - Deassertion is sampled at the next edge.
- Start acceptance:
  - Accepted when start=1, cancel=0, busy=0 and op<=9.
  - start while busy, with cancel=1, or with op 10-15 is ignored entirely.
- MTHI/MTLO (op 8/9):
  - hi (or lo) <= a at the accepting edge.
  - No busy, no done.
- States: IDLE, MUL, DIV, FIX.
- MUL (ops 0,1,4,5,6,7):
  - Accepting edge E0:
    - Form the 2*WIDTH product: signed (sign-extend) for 0/4/6, unsigned for 1/5/7.
    - For MADD/MSUB forms, compute {hi,lo} +/- product (mod 2^(2*WIDTH)) using the HI/LO values at E0.
    - Hold the result internally; counter <= MUL_LAT.
  - Counter decrements each edge. busy=1 for MUL_LAT cycles after E0.
  - At edge E0+MUL_LAT: {hi,lo} <= held result; busy falls; done=1 for one cycle.
- DIV (ops 2,3):
  - E0 latches operands. Signed ops take absolute values and record the quotient and remainder signs.
  - WIDTH restoring iterations, one per edge (state DIV), then one FIX edge applying signs. Total busy = WIDTH+1 cycles.
  - At the FIX edge: lo <= quotient, hi <= remainder; busy falls; done=1.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed min / -1: lo = 2^(WIDTH-1) pattern, hi = 0 (wraps, no trap).
  - b=0: full latency still runs; at completion hi/lo are left unchanged, done=1, dz=1.
- Abort:
  - cancel=1 while busy (no reset): at the next edge go to IDLE, busy=0.
  - hi/lo keep their pre-issue values; no done, no dz.
- done/dz:
  - Registered, valid the cycle after the commit edge, together with the new hi/lo.
  - Both 0 in all other cycles.
- Back-to-back: a new start is accepted in the same cycle done=1 (busy=0 then).
- hi/lo change only at: MTHI/MTLO acceptance, op completion, reset.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA. hi/lo hold old values while busy.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO 5, MTHI 0; MADD 3*4 -> hi=0, lo=0x11. Reload hi:lo=0:5; MSUB 1*6 -> hi=lo=0xFFFFFFFF.
- DIVU with b=0, hi=0x12, lo=0x34 -> after 33 cycles done=1, dz=1, hi/lo unchanged.
- During busy DIV: start MULT -> ignored. Cancel at busy cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged. start+cancel together in IDLE -> nothing happens.
- Assert reset between edges at busy cycle 3 of MULT -> hi=lo=0, busy=0 immediately without a clock edge. After release, MTHI 7 -> hi=7.

Source files
------------

// File: rtl/md_iter_unit.sv
// md_iter_unit: HI/LO multiply/divide unit with fixed-latency multiply and an iterative restoring divider
module md_iter_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             dz
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] res, prod, ae, be, acc;
    logic [WIDTH-1:0]   rem, quo, dv, df;
    logic [WIDTH:0]     sh;
    logic               qneg, rneg, dzf, ge;
    logic               accept, is_mul, is_div, commit_mul, commit_div, sgn;

    assign busy   = state != IDLE;
    assign accept = start && !cancel && !busy && op <= 4'd9;
    assign is_div = accept && op[3:1] == 3'd1;
    assign is_mul = accept && op <= 4'd7 && op[3:1] != 3'd1;
    // Even op codes of the multiply/divide families are the signed variants
    assign sgn    = !op[0];
    // Extending both operands to 2*WIDTH makes one truncated multiply serve signed and unsigned
    assign ae     = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign be     = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign prod   = ae * be;
    assign acc    = {hi, lo};
    // One restoring step: shift in the next dividend bit, subtract when it fits
    assign sh     = {rem, quo[WIDTH-1]};
    assign ge     = sh >= {1'b0, dv};
    assign df     = sh[WIDTH-1:0] - dv;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and commit strobes; cancel overrides completion
    always_comb begin
        state_n    = state;
        commit_mul = 1'b0;
        commit_div = 1'b0;
        case (state)
            IDLE: state_n = is_mul ? MUL : is_div ? DIV : IDLE;
            MUL: begin
                commit_mul = !cancel && cnt == CNT_W'(1);
                state_n    = (cancel || cnt == CNT_W'(1)) ? IDLE : MUL;
            end
            DIV:     state_n = cancel ? IDLE : cnt == CNT_W'(1) ? FIX : DIV;
            default: begin
                commit_div = !cancel;
                state_n    = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO commit and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            res  <= '0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dv   <= '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
            dzf  <= 1'b0;
            done <= 1'b0;
            dz   <= 1'b0;
        end else begin
            done <= commit_mul || commit_div;
            dz   <= commit_div && dzf;
            if (accept && op == 4'd8) hi <= a;
            if (accept && op == 4'd9) lo <= a;
            if (is_mul) begin
                res <= !op[2] ? prod : op[1] ? acc - prod : acc + prod;
                cnt <= CNT_W'(MUL_LAT);
            end
            if (is_div) begin
                quo  <= (sgn && a[WIDTH-1]) ? -a : a;
                dv   <= (sgn && b[WIDTH-1]) ? -b : b;
                rem  <= '0;
                qneg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg <= sgn && a[WIDTH-1];
                dzf  <= b == '0;
                cnt  <= CNT_W'(WIDTH);
            end
            if (state == MUL || state == DIV) cnt <= cnt - 1'b1;
            if (state == DIV) begin
                rem <= ge ? df : sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ge};
            end
            if (commit_mul) {hi, lo} <= res;
            if (commit_div && !dzf) begin
                lo <= qneg ? -quo : quo;
                hi <= rneg ? -rem : rem;
            end
        end
    end
endmodule

// File: tb/tb_md_iter_unit.sv
// tb_md_iter_unit: randomized scoreboard bench for md_iter_unit against an arithmetic reference model
module tb_md_iter_unit;
    logic        clk = 1'b0;
    logic        reset, start, cancel, done, dz, busy;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [64:0] sb[$];
    logic [64:0] exp_m;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    md_iter_unit #(.WIDTH(32), .MUL_LAT(5), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done hi=%h lo=%h expected no done", hi, lo);
            end else begin
                exp_m = sb.pop_front();
                if ({hi, lo, dz} !== exp_m) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                             hi, lo, dz, exp_m[64:33], exp_m[32:1], exp_m[0]);
                end
            end
        end else if (!reset && dz) begin
            checks++;
            errors++;
            $display("FAIL dz_stray: got dz=1 expected 0 without done");
        end
    end

    // Reference: returns {hi, lo, dz} after the op, from the current model HI/LO
    function automatic logic [64:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p, acc;
        int sx, sy;
        acc = {mhi, mlo};
        sx  = x;
        sy  = y;
        p   = o[0] ? {32'b0, x} * {32'b0, y} : 64'(longint'(sx) * longint'(sy));
        case (o)
            4'd0, 4'd1: return {p, 1'b0};
            4'd4, 4'd5: return {acc + p, 1'b0};
            4'd6, 4'd7: return {acc - p, 1'b0};
            4'd2: begin
                if (y == 0) return {acc, 1'b1};
                if (x == 32'h8000_0000 && y == 32'hffff_ffff) return {32'h0, 32'h8000_0000, 1'b0};
                return {32'(sx % sy), 32'(sx / sy), 1'b0};
            end
            4'd3: begin
                if (y == 0) return {acc, 1'b1};
                return {x % y, x / y, 1'b0};
            end
            4'd8:    return {x, mlo, 1'b0};
            4'd9:    return {mhi, x, 1'b0};
            default: return {acc, 1'b0};
        endcase
    endfunction

    // Issue one op at the current negedge; for long ops, track busy and an optional ignored start
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
        logic [64:0] e;
        int n, lat;
        e = model(o, x, y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        if (o <= 4'd7) begin
            lat = (o == 4'd2 || o == 4'd3) ? 33 : 5;
            sb.push_back(e);
            chk("hold_while_busy", {hi, lo}, {mhi, mlo});
            n = 0;
            while (busy && n < 100) begin
                n++;
                if (n == poke) begin
                    op = 4'd0;
                    a = 32'd3;
                    b = 32'd3;
                end
                start = (n == poke);
                @(negedge clk);
            end
            start = 1'b0;
            chk("latency", 64'(n), 64'(lat));
            chk("done_pulse", {63'b0, done}, 64'd1);
            if (!e[0]) {mhi, mlo} = e[64:1];
        end else begin
            chk("no_busy", {63'b0, busy}, 64'd0);
            {mhi, mlo} = e[64:1];
            chk("mt_noop_hilo", {hi, lo}, {mhi, mlo});
        end
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] rx, ry;
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_status", {61'b0, busy, done, dz}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'd0, 32'hffff_fffe, 32'd3, 0);
        chk("mult", {hi, lo}, 64'hffff_ffff_ffff_fffa);
        run_op(4'd1, 32'hffff_fffe, 32'd3, 0);
        chk("multu", {hi, lo}, 64'h0000_0002_ffff_fffa);
        run_op(4'd2, 32'hffff_fff9, 32'd2, 5);
        chk("div_neg", {hi, lo}, 64'hffff_ffff_ffff_fffd);
        run_op(4'd3, 32'd7, 32'd2, 0);
        chk("divu", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(4'd2, 32'h8000_0000, 32'hffff_ffff, 0);
        chk("div_min", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(4'd9, 32'd5, 32'd0, 0);
        run_op(4'd8, 32'd0, 32'd0, 0);
        run_op(4'd4, 32'd3, 32'd4, 0);
        chk("madd", {hi, lo}, 64'h0000_0000_0000_0011);
        run_op(4'd9, 32'd5, 32'd0, 0);
        run_op(4'd8, 32'd0, 32'd0, 0);
        run_op(4'd6, 32'd1, 32'd6, 0);
        chk("msub", {hi, lo}, 64'hffff_ffff_ffff_ffff);
        run_op(4'd8, 32'h12, 32'd0, 0);
        run_op(4'd9, 32'h34, 32'd0, 0);
        run_op(4'd3, 32'd5, 32'd0, 0);
        chk("divz_hilo", {hi, lo}, 64'h0000_0012_0000_0034);
        run_op(4'd12, 32'd1, 32'd2, 0);

        // Abort a divide at busy cycle 10
        start = 1'b1;
        op = 4'd2;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {63'b0, busy}, 64'd0);
        chk("cancel_hilo", {hi, lo}, {mhi, mlo});
        repeat (40) @(negedge clk);

        // start qualified by cancel in IDLE does nothing
        start = 1'b1;
        cancel = 1'b1;
        op = 4'd8;
        a = 32'h5555;
        @(negedge clk);
        op = 4'd0;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        chk("startcancel_busy", {63'b0, busy}, 64'd0);
        chk("startcancel_hilo", {hi, lo}, {mhi, mlo});
        repeat (8) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 11));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 4))
                0: ry = '0;
                1: ry = $urandom_range(1, 5);
                2: rx = $urandom_range(0, 40);
                default: ;
            endcase
            run_op(ro, rx, ry, $urandom_range(0, 3));
        end

        // Asynchronous reset mid-multiply
        run_op(4'd9, 32'hdead, 32'd0, 0);
        start = 1'b1;
        op = 4'd0;
        a = 32'hffff_fffe;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        chk("async_reset_status", {61'b0, busy, done, dz}, 64'd0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(4'd8, 32'd7, 32'd0, 0);
        chk("mthi_after_reset", {32'b0, hi}, 64'd7);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
